// File: rtl/acc_bank.sv
// ---------------------------------------------------------------------------
// acc_bank -- small bank of WIDTH-bit working registers with a shared ALU.
//
// One register (wr_addr) may be updated per clock by load / clear /
// increment / decrement / shift / rotate. A free-running phase counter
// optionally gates writes to its last phase. Carry and zero flags record
// the outcome of the most recent committed operation.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   enable     in   operation strobe
//   mode       in   [2:0] operation select (000 hold .. 111 rotate left)
//   wr_addr    in   [AW-1:0] target register
//   rd_addr    in   [AW-1:0] read-port select
//   D          in   [WIDTH-1:0] load data
//   ser_in     in   serial bit shifted in by the shift modes
//   Q          out  [WIDTH-1:0] register[rd_addr], combinational, 0 if out of range
//   c_flag     out  carry / borrow / shifted-out bit of the last commit
//   z_flag     out  result of the last commit was zero
//   phase      out  [PW-1:0] phase count 0..PHASES-1
//   phase_last out  phase == PHASES-1
// ---------------------------------------------------------------------------
module acc_bank #(
   parameter int WIDTH       = 4,
   parameter int NREGS       = 4,
   parameter int PHASES      = 2,
   parameter int COMMIT_LAST = 0,
   localparam int AW = (NREGS  > 2) ? $clog2(NREGS)  : 1,
   localparam int PW = (PHASES > 2) ? $clog2(PHASES) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [2:0]       mode,
   input  logic [AW-1:0]    wr_addr,
   input  logic [AW-1:0]    rd_addr,
   input  logic [WIDTH-1:0] D,
   input  logic             ser_in,
   output logic [WIDTH-1:0] Q,
   output logic             c_flag,
   output logic             z_flag,
   output logic [PW-1:0]    phase,
   output logic             phase_last
);

   logic [NREGS-1:0][WIDTH-1:0] regs_q, regs_d;
   logic                        c_q, c_d;
   logic                        z_q, z_d;
   logic [PW-1:0]               phase_q, phase_d;

   logic [WIDTH-1:0]            cur_s;
   logic [WIDTH-1:0]            res_s;
   logic                        cout_s;
   logic                        last_s;
   logic                        addr_ok_s;
   logic                        commit_s;

   // Phase decode and commit qualification
   always_comb begin
      last_s    = (phase_q == PW'(PHASES - 1));
      addr_ok_s = (32'(wr_addr) < NREGS);
      commit_s  = enable && (mode != 3'b000) && addr_ok_s &&
                  ((COMMIT_LAST == 0) || last_s);
   end

   // Operand fetch: current contents of the target register (0 when out of range)
   always_comb begin
      cur_s = '0;
      for (int i = 0; i < NREGS; i++) begin
         cur_s = (wr_addr == AW'(i)) ? regs_q[i] : cur_s;
      end
   end

   // ALU: result and carry-out for each mode; the extra bit of each
   // concatenation is the carry, borrow or the bit pushed off the end
   always_comb begin
      res_s  = cur_s;
      cout_s = c_q;
      case (mode)
         3'b001:  begin res_s = D;  cout_s = 1'b0; end
         3'b010:  begin res_s = '0; cout_s = 1'b0; end
         3'b011:  {cout_s, res_s} = {1'b0, cur_s} + (WIDTH + 1)'(1);
         3'b100:  {cout_s, res_s} = {1'b0, cur_s} - (WIDTH + 1)'(1);
         3'b101:  {cout_s, res_s} = {cur_s, ser_in};
         3'b110:  {res_s, cout_s} = {ser_in, cur_s};
         3'b111:  {cout_s, res_s} = {cur_s, cur_s[WIDTH-1]};
         default: begin res_s = cur_s; cout_s = c_q; end
      endcase
   end

   // Next-state: only the addressed register and the flags change on a commit
   always_comb begin
      regs_d  = regs_q;
      c_d     = c_q;
      z_d     = z_q;
      phase_d = last_s ? '0 : phase_q + PW'(1);
      if (commit_s) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = (wr_addr == AW'(i)) ? res_s : regs_q[i];
         end
         c_d = cout_s;
         z_d = (res_s == '0);
      end else begin
         regs_d = regs_q;
         c_d    = c_q;
         z_d    = z_q;
      end
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         regs_q  <= '0;
         c_q     <= 1'b0;
         z_q     <= 1'b0;
         phase_q <= '0;
      end else begin
         regs_q  <= regs_d;
         c_q     <= c_d;
         z_q     <= z_d;
         phase_q <= phase_d;
      end
   end

   // Read port: stored contents only, so a same-cycle write is not visible
   always_comb begin
      Q = '0;
      for (int i = 0; i < NREGS; i++) begin
         Q = (rd_addr == AW'(i)) ? regs_q[i] : Q;
      end
   end

   assign c_flag     = c_q;
   assign z_flag     = z_q;
   assign phase      = phase_q;
   assign phase_last = last_s;

endmodule

// File: tb/tb_acc_bank.sv
// ---------------------------------------------------------------------------
// tb_acc_bank -- self-checking bench for acc_bank.
// Two instances share all inputs: u0 uses the defaults, u1 uses NREGS=3,
// PHASES=3, COMMIT_LAST=1. An arithmetic reference model tracks both.
// ---------------------------------------------------------------------------
module tb_acc_bank;

   localparam int MOD = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [2:0] mode;
   logic [1:0] wr_addr;
   logic [1:0] rd_addr;
   logic [3:0] D;
   logic       ser_in;

   logic [3:0] q0, q1;
   logic       c0, c1, z0, z1, pl0, pl1;
   logic [0:0] ph0;
   logic [1:0] ph1;

   int checks = 0;
   int errors = 0;

   // reference model state: [instance][register]
   int mr[2][4];
   int mc[2], mz[2], mph[2];

   typedef struct {
      logic       en;
      logic [2:0] md;
      logic [1:0] wr;
      logic [3:0] d;
      logic       ser;
      logic [1:0] rd;
      logic [3:0] eq;
      logic       ec;
      logic       ez;
   } vec_t;

   vec_t tbl[15];

   acc_bank u0 (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .wr_addr(wr_addr), .rd_addr(rd_addr), .D(D), .ser_in(ser_in),
      .Q(q0), .c_flag(c0), .z_flag(z0), .phase(ph0), .phase_last(pl0)
   );

   acc_bank #(.WIDTH(4), .NREGS(3), .PHASES(3), .COMMIT_LAST(1)) u1 (
      .clk(clk), .reset(reset), .enable(enable), .mode(mode),
      .wr_addr(wr_addr), .rd_addr(rd_addr), .D(D), .ser_in(ser_in),
      .Q(q1), .c_flag(c1), .z_flag(z1), .phase(ph1), .phase_last(pl1)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic int nregs(int k);
      return (k == 0) ? 4 : 3;
   endfunction

   function automatic int nphases(int k);
      return (k == 0) ? 2 : 3;
   endfunction

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int r = 0; r < 4; r++) mr[k][r] = 0;
         mc[k] = 0; mz[k] = 0; mph[k] = 0;
      end
   endfunction

   // one rising edge with reset high, using the inputs held across it
   function automatic void model_edge();
      for (int k = 0; k < 2; k++) begin
         int v, res, cy, wr, ser;
         bit gate;
         wr   = int'(wr_addr);
         ser  = int'(ser_in);
         v    = (wr < nregs(k)) ? mr[k][wr] : 0;
         res  = v;
         cy   = mc[k];
         gate = (k == 0) || (mph[k] == nphases(k) - 1);
         if (enable && mode != 3'b000 && wr < nregs(k) && gate) begin
            case (mode)
               3'd1:    begin res = int'(D);        cy = 0; end
               3'd2:    begin res = 0;              cy = 0; end
               3'd3:    begin res = (v + 1) % MOD;  cy = (v == MOD - 1) ? 1 : 0; end
               3'd4:    begin res = (v + MOD - 1) % MOD; cy = (v == 0) ? 1 : 0; end
               3'd5:    begin res = (v * 2 + ser) % MOD; cy = v / 8; end
               3'd6:    begin res = v / 2 + ser * 8; cy = v % 2; end
               3'd7:    begin res = (v * 2) % MOD + v / 8; cy = v / 8; end
               default: begin res = v; cy = mc[k]; end
            endcase
            mr[k][wr] = res;
            mc[k]     = cy;
            mz[k]     = (res == 0) ? 1 : 0;
         end
         mph[k] = (mph[k] + 1) % nphases(k);
      end
   endfunction

   function automatic int mq(int k);
      int rd;
      rd = int'(rd_addr);
      return (rd < nregs(k)) ? mr[k][rd] : 0;
   endfunction

   task automatic check1(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input string tag);
      check1({tag, " q0"},  int'(q0),  mq(0));
      check1({tag, " c0"},  int'(c0),  mc[0]);
      check1({tag, " z0"},  int'(z0),  mz[0]);
      check1({tag, " ph0"}, int'(ph0), mph[0]);
      check1({tag, " pl0"}, int'(pl0), (mph[0] == 1) ? 1 : 0);
      check1({tag, " q1"},  int'(q1),  mq(1));
      check1({tag, " c1"},  int'(c1),  mc[1]);
      check1({tag, " z1"},  int'(z1),  mz[1]);
      check1({tag, " ph1"}, int'(ph1), mph[1]);
      check1({tag, " pl1"}, int'(pl1), (mph[1] == 2) ? 1 : 0);
   endtask

   // sweep every read address; takes 4 time units
   task automatic check_all(input string tag);
      for (int r = 0; r < 4; r++) begin
         rd_addr = 2'(r);
         #1;
         check_outputs(tag);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (reset) model_edge();
      #1;
      check_outputs(tag);
   endtask

   initial begin
      //             en    mode    wr    D     ser   rd    Q     c     z
      tbl[0]  = '{1'b1, 3'b001, 2'd2, 4'hA, 1'b0, 2'd2, 4'hA, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 3'b001, 2'd1, 4'hF, 1'b0, 2'd1, 4'hF, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 3'b011, 2'd1, 4'h0, 1'b0, 2'd1, 4'h0, 1'b1, 1'b1};
      tbl[3]  = '{1'b1, 3'b100, 2'd1, 4'h0, 1'b0, 2'd1, 4'hF, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 3'b001, 2'd0, 4'h9, 1'b0, 2'd0, 4'h9, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 3'b101, 2'd0, 4'h0, 1'b1, 2'd0, 4'h3, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 3'b110, 2'd0, 4'h0, 1'b0, 2'd0, 4'h1, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 3'b001, 2'd3, 4'h8, 1'b0, 2'd3, 4'h8, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 3'b111, 2'd3, 4'h0, 1'b0, 2'd3, 4'h1, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 3'b010, 2'd2, 4'h5, 1'b0, 2'd2, 4'h0, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 3'b000, 2'd1, 4'h5, 1'b0, 2'd1, 4'hF, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 3'b011, 2'd1, 4'h5, 1'b0, 2'd1, 4'hF, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 3'b100, 2'd2, 4'h0, 1'b0, 2'd2, 4'hF, 1'b1, 1'b0};
      tbl[13] = '{1'b1, 3'b110, 2'd1, 4'h0, 1'b1, 2'd1, 4'hF, 1'b1, 1'b0};
      tbl[14] = '{1'b1, 3'b011, 2'd1, 4'h0, 1'b0, 2'd3, 4'h1, 1'b1, 1'b1};

      reset = 1'b0; enable = 1'b0; mode = 3'b000; wr_addr = 2'd0;
      rd_addr = 2'd0; D = 4'h0; ser_in = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      reset = 1'b1;

      // directed table, default instance checked against constants
      for (int i = 0; i < 15; i++) begin
         enable = tbl[i].en; mode = tbl[i].md; wr_addr = tbl[i].wr;
         D = tbl[i].d; ser_in = tbl[i].ser; rd_addr = tbl[i].rd;
         step("tbl");
         check1($sformatf("tbl%0d Q", i), int'(q0), int'(tbl[i].eq));
         check1($sformatf("tbl%0d c", i), int'(c0), int'(tbl[i].ec));
         check1($sformatf("tbl%0d z", i), int'(z0), int'(tbl[i].ez));
      end

      // asynchronous reset between edges clears everything at once
      #1;
      reset = 1'b0;
      model_reset();
      #1;
      check1("arst q0", int'(q0), 0);
      check1("arst c0", int'(c0), 0);
      check1("arst ph0", int'(ph0), 0);
      check_all("arst");
      enable = 1'b1; mode = 3'b001; wr_addr = 2'd0; D = 4'h5; rd_addr = 2'd0;
      step("rstlow");
      reset = 1'b1;

      // gated commits: write lands only on the last-phase edge of u1
      step("gate1");
      check1("gate1 ph0", int'(ph0), 1);
      check1("gate1 ph1", int'(ph1), 1);
      check1("gate1 q1", int'(q1), 0);
      step("gate2");
      check1("gate2 ph1", int'(ph1), 2);
      check1("gate2 pl1", int'(pl1), 1);
      check1("gate2 q1", int'(q1), 0);
      step("gate3");
      check1("gate3 ph1", int'(ph1), 0);
      check1("gate3 q1", int'(q1), 5);

      // out-of-range write on u1 at its last phase changes nothing
      mode = 3'b000;
      step("idle");
      step("idle");
      mode = 3'b010; wr_addr = 2'd3; rd_addr = 2'd3;
      step("oob");
      check1("oob c1", int'(c1), 0);
      check1("oob z1", int'(z1), 0);
      check1("oob q1", int'(q1), 0);
      rd_addr = 2'd0;
      #1;
      check1("oob reg0", int'(q1), 5);
      check_all("oob");

      // randomized traffic with occasional asynchronous resets
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            #1;
            reset = 1'b0;
            model_reset();
            #1;
            check_outputs("rrst");
            enable = 1'b1; mode = 3'b011;
            step("rrst_hold");
            reset = 1'b1;
         end else begin
            enable  = ($urandom_range(0, 7) != 0);
            mode    = 3'($urandom);
            wr_addr = 2'($urandom);
            D       = 4'($urandom);
            ser_in  = 1'($urandom);
            rd_addr = 2'($urandom);
            #1;
            check_outputs("pre");
            step("rnd");
         end
      end
      check_all("final");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
